// File: rtl/bus_datapath_pkg.sv
// Shared constants for the single-bus datapath: data width, GPR count and ALU opcodes.
package bus_datapath_pkg;

   localparam int WIDTH = 32;
   localparam int NREGS = 16;

   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_OR   = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHRA = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_MUL  = 5'b01001;
   localparam logic [4:0] OP_DIV  = 5'b01010;
   localparam logic [4:0] OP_NEG  = 5'b01011;
   localparam logic [4:0] OP_NOT  = 5'b01100;

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; the 64-bit result feeds Z/ZHI/ZLO.
module bus_alu
   import bus_datapath_pkg::*;
(
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result
);

   logic signed [2*WIDTH-1:0] sa;
   logic signed [2*WIDTH-1:0] sb;
   logic [4:0]                shamt;
   logic [WIDTH-1:0]          hi;
   logic [WIDTH-1:0]          lo;

   assign sa    = {{WIDTH{a[WIDTH-1]}}, a};
   assign sb    = {{WIDTH{b[WIDTH-1]}}, b};
   assign shamt = b[4:0];

   // Rotates shift a doubled copy of A so a zero amount falls out naturally.
   always_comb begin
      lo = '0;
      hi = '0;
      case (opcode)
         OP_AND:  lo = a & b;
         OP_OR:   lo = a | b;
         OP_SUB:  lo = a - b;
         OP_ADD:  lo = a + b;
         OP_SHR:  lo = a >> shamt;
         OP_SHRA: lo = $signed(a) >>> shamt;
         OP_SHL:  lo = a << shamt;
         OP_ROR:  lo = WIDTH'({a, a} >> shamt);
         OP_ROL:  lo = WIDTH'({a, a} >> (WIDTH - int'(shamt)));
         OP_MUL:  {hi, lo} = sa * sb;
         OP_DIV: begin
            if (b != '0) begin
               lo = WIDTH'(sa / sb);
               hi = WIDTH'(sa % sb);
            end
         end
         OP_NEG:  lo = -b;
         OP_NOT:  lo = ~b;
         default: ;
      endcase
   end

   assign result = {hi, lo};

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: GPRs, special registers and Z around bus_alu, all sharing one bus.
module bus_datapath
   import bus_datapath_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic               R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic               R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic               R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic               HIin, Loin, PCin, MDRin, MARin, IRin, Yin,
   input  logic               Zin, ZHIin, ZLOin,
   input  logic               HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout, Cout, InPortout,
   input  logic               MDRread,
   input  logic               IncPC,
   input  logic               ZHighSelect, ZLowSelect,
   input  logic [4:0]         ALU_opcode,
   input  logic [WIDTH-1:0]   Mdatain,
   output logic [WIDTH-1:0]   R0, R1, R2, R3, R4, R5, R6, R7,
   output logic [WIDTH-1:0]   R8, R9, R10, R11, R12, R13, R14, R15,
   output logic [WIDTH-1:0]   HI, LO, Y, ZLO, ZHI, IR,
   output logic [2*WIDTH-1:0] Z_register
);

   logic [WIDTH-1:0]   gpr [NREGS];
   logic [NREGS-1:0]   r_in;
   logic [NREGS-1:0]   r_out;
   logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q;
   logic [2*WIDTH-1:0] z_q;
   logic [WIDTH-1:0]   bus;
   logic [WIDTH-1:0]   c_sext;
   logic [2*WIDTH-1:0] alu_result;

   assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   assign c_sext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

   // Earlier sources win when several drivers are asserted; the reverse loop lets the lowest GPR win.
   always_comb begin
      bus = '0;
      if (|r_out) begin
         for (int i = NREGS - 1; i >= 0; i--) begin
            if (r_out[i]) bus = gpr[i];
         end
      end
      else if (HIout)     bus = hi_q;
      else if (Loout)     bus = lo_q;
      else if (ZHIout)    bus = zhi_q;
      else if (ZLOout)    bus = zlo_q;
      else if (PCout)     bus = pc_q;
      else if (MDRout)    bus = mdr_q;
      else if (Yout)      bus = y_q;
      else if (Cout)      bus = c_sext;
      else if (InPortout) bus = '0;
   end

   bus_alu u_alu (
      .opcode (ALU_opcode),
      .a      (y_q),
      .b      (bus),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         z_q   <= '0;
         zhi_q <= '0;
         zlo_q <= '0;
      end
      else begin
         for (int i = 0; i < NREGS; i++) begin
            if (r_in[i]) gpr[i] <= bus;
         end
         if (HIin)  hi_q  <= bus;
         if (Loin)  lo_q  <= bus;
         if (IRin)  ir_q  <= bus;
         if (MARin) mar_q <= bus;
         if (Yin)   y_q   <= bus;
         if (MDRin) mdr_q <= MDRread ? Mdatain : bus;
         // Increment outranks a bus load so fetch sequencing cannot be clobbered.
         if (IncPC)     pc_q <= pc_q + WIDTH'(1);
         else if (PCin) pc_q <= bus;
         if (Zin)    z_q   <= alu_result;
         if (ZHIin)  zhi_q <= ZHighSelect ? alu_result[2*WIDTH-1:WIDTH] : z_q[2*WIDTH-1:WIDTH];
         if (ZLOin)  zlo_q <= ZLowSelect  ? alu_result[WIDTH-1:0]       : z_q[WIDTH-1:0];
      end
   end

   assign R0  = gpr[0];   assign R1  = gpr[1];   assign R2  = gpr[2];   assign R3  = gpr[3];
   assign R4  = gpr[4];   assign R5  = gpr[5];   assign R6  = gpr[6];   assign R7  = gpr[7];
   assign R8  = gpr[8];   assign R9  = gpr[9];   assign R10 = gpr[10];  assign R11 = gpr[11];
   assign R12 = gpr[12];  assign R13 = gpr[13];  assign R14 = gpr[14];  assign R15 = gpr[15];

   assign HI         = hi_q;
   assign LO         = lo_q;
   assign Y          = y_q;
   assign ZLO        = zlo_q;
   assign ZHI        = zhi_q;
   assign IR         = ir_q;
   assign Z_register = z_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: an ALU vector table plus hand sequences for bus, PC and reset behaviour.
module tb_bus_datapath;

   logic        clk;
   logic        clr;
   logic [15:0] r_in, r_out;
   logic        HIin, Loin, PCin, MDRin, MARin, IRin, Yin, Zin, ZHIin, ZLOin;
   logic        HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout, Cout, InPortout;
   logic        MDRread, IncPC, ZHighSelect, ZLowSelect;
   logic [4:0]  ALU_opcode;
   logic [31:0] Mdatain;
   logic [31:0] r_q [16];
   logic [31:0] HI, LO, Y, ZLO, ZHI, IR;
   logic [63:0] Z_register;

   int checks;
   int failures;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] z;
   } alu_vec_t;

   alu_vec_t vecs [18];

   bus_datapath dut (
      .clk(clk), .clr(clr),
      .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
      .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
      .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
      .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
      .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
      .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
      .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
      .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
      .HIin(HIin), .Loin(Loin), .PCin(PCin), .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin),
      .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
      .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout),
      .ZHIout(ZHIout), .ZLOout(ZLOout), .Cout(Cout), .InPortout(InPortout),
      .MDRread(MDRread), .IncPC(IncPC), .ZHighSelect(ZHighSelect), .ZLowSelect(ZLowSelect),
      .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
      .R0(r_q[0]), .R1(r_q[1]), .R2(r_q[2]), .R3(r_q[3]),
      .R4(r_q[4]), .R5(r_q[5]), .R6(r_q[6]), .R7(r_q[7]),
      .R8(r_q[8]), .R9(r_q[9]), .R10(r_q[10]), .R11(r_q[11]),
      .R12(r_q[12]), .R13(r_q[13]), .R14(r_q[14]), .R15(r_q[15]),
      .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .IR(IR),
      .Z_register(Z_register)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clearCtrl();
      r_in = '0;  r_out = '0;
      HIin = 0; Loin = 0; PCin = 0; MDRin = 0; MARin = 0; IRin = 0; Yin = 0;
      Zin = 0; ZHIin = 0; ZLOin = 0;
      HIout = 0; Loout = 0; PCout = 0; MDRout = 0; Yout = 0;
      ZHIout = 0; ZLOout = 0; Cout = 0; InPortout = 0;
      MDRread = 0; IncPC = 0; ZHighSelect = 0; ZLowSelect = 0;
      ALU_opcode = '0;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearCtrl();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic loadMdr(input logic [31:0] v);
      Mdatain = v;
      MDRread = 1;
      MDRin   = 1;
      applyStimulus();
   endtask

   task automatic loadReg(input int idx, input logic [31:0] v);
      loadMdr(v);
      MDRout     = 1;
      r_in[idx]  = 1;
      applyStimulus();
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0]  = '{op: 5'b00000, a: 32'hF0F0_1234, b: 32'h0FF0_FF00, z: 64'h0000_0000_00F0_1200};
      vecs[1]  = '{op: 5'b00001, a: 32'hF000_0001, b: 32'h0000_0F00, z: 64'h0000_0000_F000_0F01};
      vecs[2]  = '{op: 5'b00010, a: 32'h0000_0005, b: 32'h0000_0007, z: 64'h0000_0000_FFFF_FFFE};
      vecs[3]  = '{op: 5'b00011, a: 32'hFFFF_FFFF, b: 32'h0000_0002, z: 64'h0000_0000_0000_0001};
      vecs[4]  = '{op: 5'b00100, a: 32'h8000_0000, b: 32'h0000_0004, z: 64'h0000_0000_0800_0000};
      vecs[5]  = '{op: 5'b00101, a: 32'h8000_0000, b: 32'h0000_0004, z: 64'h0000_0000_F800_0000};
      vecs[6]  = '{op: 5'b00110, a: 32'h0000_0003, b: 32'h0000_0021, z: 64'h0000_0000_0000_0006};
      vecs[7]  = '{op: 5'b00111, a: 32'h0000_0001, b: 32'h0000_0001, z: 64'h0000_0000_8000_0000};
      vecs[8]  = '{op: 5'b01000, a: 32'h8000_0001, b: 32'h0000_0004, z: 64'h0000_0000_0000_0018};
      vecs[9]  = '{op: 5'b00111, a: 32'h1234_5678, b: 32'h0000_0000, z: 64'h0000_0000_1234_5678};
      vecs[10] = '{op: 5'b01001, a: 32'hFFFF_FFFD, b: 32'h0000_0007, z: 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[11] = '{op: 5'b01001, a: 32'h0001_0000, b: 32'h0001_0000, z: 64'h0000_0001_0000_0000};
      vecs[12] = '{op: 5'b01010, a: 32'h0000_0011, b: 32'h0000_0005, z: 64'h0000_0002_0000_0003};
      vecs[13] = '{op: 5'b01010, a: 32'hFFFF_FFEF, b: 32'h0000_0005, z: 64'hFFFF_FFFE_FFFF_FFFD};
      vecs[14] = '{op: 5'b01010, a: 32'h0000_0011, b: 32'h0000_0000, z: 64'h0000_0000_0000_0000};
      vecs[15] = '{op: 5'b01011, a: 32'h0000_0000, b: 32'h0000_0005, z: 64'h0000_0000_FFFF_FFFB};
      vecs[16] = '{op: 5'b01100, a: 32'h0000_0000, b: 32'h0000_FFFF, z: 64'h0000_0000_FFFF_0000};
      vecs[17] = '{op: 5'b01101, a: 32'h0000_0001, b: 32'h0000_0001, z: 64'h0000_0000_0000_0000};

      clearCtrl();
      Mdatain = '0;
      clr = 1'b0;
      #3;
      checkOutput("reset_r0", 64'(r_q[0]), 64'h0);
      checkOutput("reset_ir", 64'(IR), 64'h0);
      checkOutput("reset_z", Z_register, 64'h0);
      #4 clr = 1'b1;

      // MDR load path then transfer to R0
      loadMdr(32'h0000_000F);
      MDRout = 1; r_in[0] = 1;
      applyStimulus();
      checkOutput("mdr_to_r0", 64'(r_q[0]), 64'hF);

      // ADD through Y and Z with ZLO captured on the same edge
      loadReg(4, 32'h4);
      loadReg(5, 32'h12);
      r_out[4] = 1; Yin = 1;
      applyStimulus();
      checkOutput("add_y", 64'(Y), 64'h4);
      ALU_opcode = 5'b00011; r_out[5] = 1; Zin = 1; ZLOin = 1; ZLowSelect = 1;
      applyStimulus();
      checkOutput("add_z", Z_register, 64'h16);
      checkOutput("add_zlo", 64'(ZLO), 64'h16);
      ZLOout = 1; r_in[0] = 1;
      applyStimulus();
      checkOutput("add_r0", 64'(r_q[0]), 64'h16);

      for (int i = 0; i < 18; i++) begin
         loadMdr(vecs[i].a);
         MDRout = 1; Yin = 1;
         applyStimulus();
         loadMdr(vecs[i].b);
         MDRout = 1; ALU_opcode = vecs[i].op;
         Zin = 1; ZLOin = 1; ZLowSelect = 1; ZHIin = 1; ZHighSelect = 1;
         applyStimulus();
         checkOutput($sformatf("alu%0d_z", i), Z_register, vecs[i].z);
         checkOutput($sformatf("alu%0d_zlo", i), 64'(ZLO), {32'h0, vecs[i].z[31:0]});
         checkOutput($sformatf("alu%0d_zhi", i), 64'(ZHI), {32'h0, vecs[i].z[63:32]});
      end

      // ZHI/ZLO with select low take the held Z, not the live ALU result
      loadMdr(32'h0001_0000);
      MDRout = 1; Yin = 1;
      applyStimulus();
      MDRout = 1; ALU_opcode = 5'b01001; Zin = 1;
      applyStimulus();
      checkOutput("zsel_mul_z", Z_register, 64'h0000_0001_0000_0000);
      MDRout = 1; ALU_opcode = 5'b00000; ZHIin = 1; ZLOin = 1;
      applyStimulus();
      checkOutput("zsel_zhi", 64'(ZHI), 64'h1);
      checkOutput("zsel_zlo", 64'(ZLO), 64'h0);

      // IR sign extension via Cout, PC wrap with IncPC over PCin
      loadMdr(32'h0007_FFFF);
      MDRout = 1; IRin = 1;
      applyStimulus();
      checkOutput("ir_load", 64'(IR), 64'h0007_FFFF);
      Cout = 1; PCin = 1; r_in[2] = 1;
      applyStimulus();
      checkOutput("cout_sext", 64'(r_q[2]), 64'hFFFF_FFFF);
      IncPC = 1; PCin = 1; Cout = 1;
      applyStimulus();
      loadReg(3, 32'h1234);
      PCout = 1; r_in[3] = 1;
      applyStimulus();
      checkOutput("pc_wrap", 64'(r_q[3]), 64'h0);
      IncPC = 1;
      applyStimulus();
      PCout = 1; r_in[3] = 1;
      applyStimulus();
      checkOutput("pc_inc", 64'(r_q[3]), 64'h1);

      // Bus default and driver priority
      Yin = 1;
      applyStimulus();
      checkOutput("bus_idle_y", 64'(Y), 64'h0);
      loadReg(1, 32'hAAAA_0001);
      loadMdr(32'h5555_0002);
      r_out[1] = 1; MDRout = 1; r_in[2] = 1;
      applyStimulus();
      checkOutput("prio_r1_mdr", 64'(r_q[2]), 64'hAAAA_0001);
      r_out[0] = 1; r_out[1] = 1; r_in[6] = 1;
      applyStimulus();
      checkOutput("prio_r0_r1", 64'(r_q[6]), 64'h16);
      MDRout = 1; HIin = 1;
      applyStimulus();
      checkOutput("hi_load", 64'(HI), 64'h5555_0002);
      HIout = 1; Loout = 1; r_in[7] = 1;
      applyStimulus();
      checkOutput("prio_hi_lo", 64'(r_q[7]), 64'h5555_0002);

      // Asynchronous clear between edges, then normal operation resumes
      #2 clr = 1'b0;
      #1;
      checkOutput("midrst_r1", 64'(r_q[1]), 64'h0);
      checkOutput("midrst_hi", 64'(HI), 64'h0);
      checkOutput("midrst_ir", 64'(IR), 64'h0);
      checkOutput("midrst_z", Z_register, 64'h0);
      #1 clr = 1'b1;
      loadMdr(32'h0000_003C);
      MDRout = 1; r_in[8] = 1;
      applyStimulus();
      checkOutput("post_rst_load", 64'(r_q[8]), 64'h3C);
      PCout = 1; r_in[8] = 1;
      applyStimulus();
      checkOutput("post_rst_pc", 64'(r_q[8]), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
